mem_stage: RTL and testbench
============================

# mem_stage

MEM stage of the five-stage pipeline, sitting between the EX stage and `latch_wb`. It registers each instruction issued by EX. Non-memory ops pass straight through; loads and stores run a request/ready transaction on the data-memory port, with a bounded wait. It produces the WB control bits (`reg_write`, `mem_to_reg`) and data that `latch_wb` consumes, and stalls upstream while an access is outstanding.

## Interface
Parameters:
- `DATA_W`, 32: data/address width
- `REG_AW`, 5: register-file index width
- `MAX_WAIT`, 16: cycles in ACCESS without `dmem_ready` before timeout (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `ex_valid` in 1: EX presents an instruction this cycle
- `ex_reg_write`, `ex_mem_to_reg`, `ex_mem_read`, `ex_mem_write` in 1 each: control from EX
- `ex_alu_result` in DATA_W: ALU result / memory address
- `ex_write_data` in DATA_W: store data
- `ex_write_reg` in REG_AW: destination register
- `stall` out 1: upstream must hold its outputs
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out DATA_W, `dmem_wdata` out DATA_W: memory request
- `dmem_ready` in 1, `dmem_rdata` in DATA_W: memory completion and load data
- `wb_valid` out 1: one-cycle pulse, WB fields valid
- `reg_write`, `mem_to_reg` out 1 each: WB control to `latch_wb`
- `read_data` out DATA_W, `alu_result` out DATA_W, `write_reg` out REG_AW: WB data
- `mem_err` out 1: one-cycle pulse on timeout

## Operation
- States: IDLE, ACCESS.
- IDLE, `ex_valid`=0: `wb_valid`<=0, nothing else changes.
- IDLE, `ex_valid`=1, no mem op: load the WB fields from EX. `read_data` holds its value. `wb_valid`<=1. Stay in IDLE.
- IDLE, `ex_valid`=1, `ex_mem_read` or `ex_mem_write`:
  - capture all EX fields internally
  - go to ACCESS and clear the wait counter
  - `wb_valid`<=0
- `ex_mem_read` and `ex_mem_write` both set: execute as a store (`dmem_we`=1). Return no load data.
- ACCESS:
  - `dmem_req`=1; `dmem_we`, `dmem_addr`, `dmem_wdata` driven from the captured op and stable throughout
  - `stall`=1 (combinational on state); `ex_valid` ignored
- ACCESS, `dmem_ready`=1:
  - load: `read_data`<=`dmem_rdata`
  - WB fields <= captured values; `wb_valid`<=1; go to IDLE
- ACCESS, `dmem_ready`=0: counter +1. When the counter reaches MAX_WAIT:
  - `mem_err`<=1, `wb_valid`<=1
  - `reg_write`<=0 (op squashed); other WB fields <= captured values
  - go to IDLE
- `dmem_ready`=1 and the timeout hitting in the same cycle: ready wins, no error.
- `dmem_ready` in IDLE is ignored.
- Outputs at reset, and whenever `rst_n`=0 (including mid-access):
  - all outputs 0; state IDLE; counter 0
  - `dmem_req` drops immediately and the in-flight op is discarded
- WB fields hold their last value between `wb_valid` pulses.

## Timing
- Non-memory op: accepted at edge N → `wb_valid` high in cycle N+1.
- Memory op: accepted at edge N; `dmem_req` high from cycle N+1. `dmem_ready` sampled at edge M → `wb_valid` high and `stall` low in cycle M+1. Zero-wait memory gives `wb_valid` two cycles after acceptance.
- `stall` is high for exactly the ACCESS cycles. A new EX op can be accepted in the same cycle that `wb_valid` pulses.
- Timeout: `wb_valid` and `mem_err` both high in the cycle after MAX_WAIT ready-low cycles.
- `wb_valid` and `mem_err` never stay high two cycles running for a single op.

## Structure
- Shared `pipeline_pkg`:
  - state enum {IDLE, ACCESS}
  - `DATA_W` / `REG_AW` defaults
  - a struct bundling the WB control bits, shared with `latch_wb`
- One sub-module, `mem_wait_counter`:
  - ports: clear, enable, terminal-count output at MAX_WAIT
  - asynchronous active-low reset

## Test plan
- ALU op: `ex_alu_result`=0x0000_0042, `ex_write_reg`=5, `ex_reg_write`=1 → next cycle `wb_valid`=1, `alu_result`=0x42, `write_reg`=5, `stall`=0.
- Load at 0x100, memory ready after 3 cycles with `dmem_rdata`=0xDEAD_BEEF:
  - `stall`=1 for 4 cycles, `dmem_addr`=0x100
  - then `wb_valid`=1, `read_data`=0xDEAD_BEEF, `mem_to_reg`=1
- Store 0x1234_5678 to 0x20, zero wait → `dmem_we`=1 for one cycle, `dmem_wdata`=0x1234_5678, `wb_valid`=1 next cycle with `reg_write`=0.
- Load, `dmem_ready` never asserted, MAX_WAIT=16 → after 16 wait cycles `mem_err`=1 and `wb_valid`=1 for one cycle, `reg_write`=0, state IDLE.
- `rst_n` pulled low on the second cycle of ACCESS → `dmem_req`, `stall` and all outputs 0 immediately. After release, an ALU op completes normally with no `wb_valid` for the discarded load.
- Back-to-back ALU ops on consecutive cycles, then a load → one `wb_valid` per op, in order, with no gaps before the load.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Types and defaults shared across the pipeline stages.
// The WB control struct is common to mem_stage and latch_wb.
package pipeline_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Counts data-memory wait cycles.
// at_max flags that the next counted cycle is the MAX_WAIT-th one.
module mem_wait_counter #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic at_max
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count_r;

  assign at_max = (count_r == CW'(MAX_WAIT - 1));

  // Wait-cycle count, saturating one short of MAX_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && !at_max) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU ops through, runs load/store handshakes on the
// data-memory port with a bounded wait, and presents WB fields to latch_wb.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [REG_AW-1:0] ex_write_reg,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] alu_result,
  output logic [REG_AW-1:0] write_reg,
  output logic              mem_err
);

  mem_state_t        state_r, state_nxt_s;
  wb_ctrl_t          wb_ctrl_r, cap_ctrl_r;
  logic              cap_load_r, cap_we_r;
  logic [DATA_W-1:0] cap_addr_r, cap_wdata_r;
  logic [REG_AW-1:0] cap_reg_r;
  logic [DATA_W-1:0] read_data_r, alu_result_r;
  logic [REG_AW-1:0] write_reg_r;
  logic              wb_valid_r, mem_err_r;
  logic              in_access_s, is_mem_s, start_s, wait_s, at_max_s;

  assign in_access_s = (state_r == ACCESS);
  assign is_mem_s    = ex_mem_read | ex_mem_write;
  assign start_s     = (state_r == IDLE) & ex_valid & is_mem_s;
  assign wait_s      = in_access_s & ~dmem_ready;

  mem_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_s),
    .enable(wait_s),
    .at_max(at_max_s)
  );

  // Next-state decode; ready takes priority over the wait limit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (dmem_ready || at_max_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture of the accepted memory op; a read+write pair executes as a store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_ctrl_r  <= '0;
      cap_load_r  <= 1'b0;
      cap_we_r    <= 1'b0;
      cap_addr_r  <= '0;
      cap_wdata_r <= '0;
      cap_reg_r   <= '0;
    end else if (start_s) begin
      cap_ctrl_r  <= '{reg_write: ex_reg_write, mem_to_reg: ex_mem_to_reg};
      cap_load_r  <= ex_mem_read & ~ex_mem_write;
      cap_we_r    <= ex_mem_write;
      cap_addr_r  <= ex_alu_result;
      cap_wdata_r <= ex_write_data;
      cap_reg_r   <= ex_write_reg;
    end
  end

  // WB fields hold between pulses; wb_valid and mem_err pulse for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ctrl_r    <= '0;
      read_data_r  <= '0;
      alu_result_r <= '0;
      write_reg_r  <= '0;
      wb_valid_r   <= 1'b0;
      mem_err_r    <= 1'b0;
    end else begin
      wb_valid_r <= 1'b0;
      mem_err_r  <= 1'b0;
      if (state_r == IDLE) begin
        if (ex_valid && !is_mem_s) begin
          wb_ctrl_r    <= '{reg_write: ex_reg_write, mem_to_reg: ex_mem_to_reg};
          alu_result_r <= ex_alu_result;
          write_reg_r  <= ex_write_reg;
          wb_valid_r   <= 1'b1;
        end
      end else if (dmem_ready) begin
        wb_ctrl_r    <= cap_ctrl_r;
        alu_result_r <= cap_addr_r;
        write_reg_r  <= cap_reg_r;
        if (cap_load_r) begin
          read_data_r <= dmem_rdata;
        end
        wb_valid_r   <= 1'b1;
      end else if (at_max_s) begin
        wb_ctrl_r    <= '{reg_write: 1'b0, mem_to_reg: cap_ctrl_r.mem_to_reg};
        alu_result_r <= cap_addr_r;
        write_reg_r  <= cap_reg_r;
        wb_valid_r   <= 1'b1;
        mem_err_r    <= 1'b1;
      end
    end
  end

  assign stall      = in_access_s;
  assign dmem_req   = in_access_s;
  assign dmem_we    = in_access_s & cap_we_r;
  assign dmem_addr  = in_access_s ? cap_addr_r : '0;
  assign dmem_wdata = in_access_s ? cap_wdata_r : '0;
  assign wb_valid   = wb_valid_r;
  assign reg_write  = wb_ctrl_r.reg_write;
  assign mem_to_reg = wb_ctrl_r.mem_to_reg;
  assign read_data  = read_data_r;
  assign alu_result = alu_result_r;
  assign write_reg  = write_reg_r;
  assign mem_err    = mem_err_r;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: the driver predicts each op's WB
// result and completion cycle; a separate monitor checks what the DUT presents.
module tb_mem_stage;

  localparam int MAX_WAIT = 16;

  logic        clk, rst_n;
  logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write;
  logic [31:0] ex_alu_result, ex_write_data;
  logic [4:0]  ex_write_reg;
  logic        stall, dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, reg_write, mem_to_reg, mem_err;
  logic [31:0] read_data, alu_result;
  logic [4:0]  write_reg;

  mem_stage #(.DATA_W(32), .REG_AW(5), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .read_data(read_data), .alu_result(alu_result), .write_reg(write_reg), .mem_err(mem_err)
  );

  typedef struct {
    bit          rw, m2r, err, is_mem, we;
    logic [31:0] rd, alu, addr, wdata;
    logic [4:0]  wr;
    int          cyc, stall;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          mem_lat = 0;
  logic [31:0] mem_rdata_v = 32'h0;
  logic [31:0] last_rd = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory responder: ready after mem_lat low cycles; random ready while idle.
  initial begin
    int acc_cnt = 0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        dmem_ready = (acc_cnt == mem_lat);
        dmem_rdata = (acc_cnt == mem_lat) ? mem_rdata_v : $urandom;
        acc_cnt++;
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        acc_cnt = 0;
      end
    end
  end

  // Monitor: compares presented WB fields and memory-port values with the queue.
  initial begin
    int   stall_cnt = 0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        stall_cnt = 0;
      end else begin
        chk("req_eq_stall", {31'h0, dmem_req}, {31'h0, stall});
        chk("err_without_wb", {31'h0, mem_err & ~wb_valid}, 32'h0);
        if (stall) begin
          stall_cnt++;
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("dmem_addr", dmem_addr, e.addr);
            chk("dmem_we", {31'h0, dmem_we}, {31'h0, e.we});
            chk("dmem_wdata", dmem_wdata, e.wdata);
          end
        end
        if (wb_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_wb", {31'h0, wb_valid}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("reg_write", {31'h0, reg_write}, {31'h0, e.rw});
            chk("mem_to_reg", {31'h0, mem_to_reg}, {31'h0, e.m2r});
            chk("mem_err", {31'h0, mem_err}, {31'h0, e.err});
            chk("read_data", read_data, e.rd);
            chk("alu_result", alu_result, e.alu);
            chk("write_reg", {27'h0, write_reg}, {27'h0, e.wr});
            chk("wb_cycle", cyc, e.cyc);
            chk("stall_cycles", stall_cnt, e.stall);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic rand_ex();
    ex_reg_write  = 1'($urandom_range(0, 1));
    ex_mem_to_reg = 1'($urandom_range(0, 1));
    ex_mem_read   = 1'($urandom_range(0, 1));
    ex_mem_write  = 1'($urandom_range(0, 1));
    ex_alu_result = $urandom;
    ex_write_data = $urandom;
    ex_write_reg  = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (stall) begin
      ex_valid = 1'($urandom_range(0, 1));
      rand_ex();
      @(negedge clk);
      n++;
      if (n > 100) begin
        chk("stall_timeout", {31'h0, stall}, 32'h0);
        break;
      end
    end
  endtask

  task automatic bubble();
    ex_valid = 1'b0;
    rand_ex();
    @(negedge clk);
  endtask

  // Issue one op and predict its WB result from the stage's rules.
  task automatic issue_op(input bit rw, input bit m2r, input bit mr, input bit mw,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] wr, input int lat, input logic [31:0] rd);
    exp_t e;
    wait_idle();
    ex_valid = 1'b1;
    ex_reg_write = rw;  ex_mem_to_reg = m2r;
    ex_mem_read = mr;   ex_mem_write = mw;
    ex_alu_result = alu; ex_write_data = wd; ex_write_reg = wr;
    mem_lat = lat;
    mem_rdata_v = rd;
    e.is_mem = mr | mw; e.we = mw; e.addr = alu; e.wdata = wd;
    e.alu = alu; e.wr = wr; e.m2r = m2r;
    if (!e.is_mem) begin
      e.rw = rw; e.err = 1'b0; e.cyc = cyc + 1; e.stall = 0;
    end else if (lat < MAX_WAIT) begin
      e.rw = rw; e.err = 1'b0; e.cyc = cyc + 2 + lat; e.stall = lat + 1;
      if (mr && !mw) last_rd = rd;
    end else begin
      e.rw = 1'b0; e.err = 1'b1; e.cyc = cyc + 1 + MAX_WAIT; e.stall = MAX_WAIT;
    end
    e.rd = last_rd;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl"}, {25'h0, wb_valid, mem_err, stall, dmem_req, dmem_we, reg_write, mem_to_reg}, 32'h0);
    chk({tag, "_addr"}, dmem_addr, 32'h0);
    chk({tag, "_wdata"}, dmem_wdata, 32'h0);
    chk({tag, "_rdata"}, read_data, 32'h0);
    chk({tag, "_alu"}, alu_result, 32'h0);
    chk({tag, "_wreg"}, {27'h0, write_reg}, 32'h0);
  endtask

  initial begin
    int sel, kind, lat;
    rst_n = 1'b0;
    ex_valid = 1'b0;
    rand_ex();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0042, 32'h0, 5'd5, 0, 32'h0);
    issue_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
    issue_op(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 5'd0, 0, 32'h0);
    issue_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd9, 1000, 32'h0);
    issue_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0304, 32'h0, 5'd10, MAX_WAIT - 1, 32'hCAFE_0001);
    wait_idle();

    // Reset asserted in the second ACCESS cycle of a load that never completes.
    ex_valid = 1'b1; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1;
    ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_alu_result = 32'h0000_0400;
    ex_write_reg = 5'd3; mem_lat = 1000;
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_stall", {31'h0, stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    last_rd = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd12, 0, 32'h0);
    issue_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0, 5'd1, 0, 32'h0);
    issue_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0002, 32'h0, 5'd2, 0, 32'h0);
    issue_op(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd4, 1, 32'h5555_AAAA);
    issue_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0600, 32'hABCD_0000, 5'd6, 2, 32'h7777_7777);

    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        bubble();
      end else if (sel < 6) begin
        issue_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0,
                 $urandom, $urandom, 5'($urandom_range(0, 31)), 0, 32'h0);
      end else begin
        kind = $urandom_range(1, 3);
        sel = $urandom_range(0, 9);
        if (sel < 7) lat = $urandom_range(0, 4);
        else if (sel == 7) lat = MAX_WAIT - 1;
        else if (sel == 8) lat = MAX_WAIT;
        else lat = MAX_WAIT + 4;
        issue_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), kind[0], kind[1],
                 $urandom, $urandom, 5'($urandom_range(0, 31)), lat, $urandom);
      end
    end

    ex_valid = 1'b0;
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(negedge clk);
    chk("drain_queue", exp_q.size(), 32'h0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
